// File: rtl/arbiter_pkg.sv
// Shared types and counter widths for the CPU/DMA memory bus arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_OWN,
    DMA_XFER,
    YIELD
  } arb_state_t;

  localparam int unsigned BURST_W = 4;
  localparam int unsigned WAIT_W  = 3;

endpackage

// File: rtl/dma_access_timer.sv
// Wait-state and burst-length counters for DMA accesses.
// accessDone marks the last cycle of an access; burstDone means no further access fits the grant.
module dma_access_timer
  import arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic next_i,
  input  logic step_i,
  output logic access_done_o,
  output logic burst_done_o
);

  localparam logic [WAIT_W-1:0]  WaitLoad = WAIT_W'(WAIT_STATES);
  localparam logic [BURST_W:0]   MaxBurst = (BURST_W + 1)'(MAX_BURST);

  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURST_W:0]   burst_next;

  // One bit wider so the +1 comparison cannot overflow.
  assign burst_next    = {1'b0, burst_cnt_q} + (BURST_W + 1)'(1);
  assign access_done_o = (wait_cnt_q == '0);
  assign burst_done_o  = (burst_next >= MaxBurst);

  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (load_i) begin
      burst_cnt_d = '0;
      wait_cnt_d  = WaitLoad;
    end else if (next_i) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
      wait_cnt_d  = WaitLoad;
    end else if (step_i && (wait_cnt_q != '0)) begin
      wait_cnt_d  = wait_cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the CPU and one DMA requester.
// The CPU is stalled only on read cycles; each DMA burst is followed by a forced CPU cycle.
module mem_bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        extReady,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuReadNotWrite,
  output logic        cpuReady,
  output logic [7:0]  cpuDataIn,
  input  logic        dmaRequest,
  input  logic [15:0] dmaAddress,
  input  logic [7:0]  dmaWriteData,
  input  logic        dmaWrite,
  output logic        dmaGrant,
  output logic        dmaAck,
  output logic [7:0]  dmaReadData,
  output logic [15:0] memAddress,
  output logic [7:0]  memWriteData,
  output logic        memWriteEnable,
  input  logic [7:0]  memReadData
);

  arb_state_t state_q, state_d;
  logic       load, next_acc, step;
  logic       access_done, burst_done;

  dma_access_timer #(
    .MAX_BURST  (MAX_BURST),
    .WAIT_STATES(WAIT_STATES)
  ) u_timer (
    .clk_i        (clk),
    .rst_ni       (nrst),
    .load_i       (load),
    .next_i       (next_acc),
    .step_i       (step),
    .access_done_o(access_done),
    .burst_done_o (burst_done)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    next_acc = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      CPU_OWN: begin
        // CPU writes are never stalled, so the grant waits for a read cycle.
        if (dmaRequest && cpuReadNotWrite) begin
          state_d = DMA_XFER;
          load    = 1'b1;
        end
      end
      DMA_XFER: begin
        if (!access_done) begin
          step = 1'b1;
        end else if (dmaRequest && !burst_done) begin
          next_acc = 1'b1;
        end else begin
          state_d = YIELD;
        end
      end
      YIELD:   state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= CPU_OWN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    dmaGrant       = (state_q == DMA_XFER);
    dmaAck         = dmaGrant && access_done;
    cpuReady       = extReady && !dmaGrant;
    memAddress     = dmaGrant ? dmaAddress : cpuAddress;
    memWriteData   = dmaGrant ? dmaWriteData : cpuDataOut;
    // One write strobe per DMA access, issued in its final cycle.
    memWriteEnable = dmaGrant ? (dmaWrite && access_done) : !cpuReadNotWrite;
    cpuDataIn      = memReadData;
    dmaReadData    = memReadData;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with no wait states, one with two.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ext_ready;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rnw;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_write;

  logic        cpu_ready0, dma_grant0, dma_ack0, mem_we0;
  logic [7:0]  cpu_din0, dma_rdata0, mem_wdata0, mem_rdata0;
  logic [15:0] mem_addr0;
  logic        cpu_ready2, dma_grant2, dma_ack2, mem_we2;
  logic [7:0]  cpu_din2, dma_rdata2, mem_wdata2, mem_rdata2;
  logic [15:0] mem_addr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hCD31: mem_rd = 8'hF0;
      16'hCCDD: mem_rd = 8'h5A;
      default:  mem_rd = a[7:0] ^ a[15:8];
    endcase
  endfunction

  assign mem_rdata0 = mem_rd(mem_addr0);
  assign mem_rdata2 = mem_rd(mem_addr2);

  mem_bus_arbiter #(.MAX_BURST(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .extReady(ext_ready), .cpuAddress(cpu_addr),
    .cpuDataOut(cpu_dout), .cpuReadNotWrite(cpu_rnw), .cpuReady(cpu_ready0),
    .cpuDataIn(cpu_din0), .dmaRequest(dma_req), .dmaAddress(dma_addr),
    .dmaWriteData(dma_wdata), .dmaWrite(dma_write), .dmaGrant(dma_grant0),
    .dmaAck(dma_ack0), .dmaReadData(dma_rdata0), .memAddress(mem_addr0),
    .memWriteData(mem_wdata0), .memWriteEnable(mem_we0), .memReadData(mem_rdata0)
  );

  mem_bus_arbiter #(.MAX_BURST(4), .WAIT_STATES(2)) dut2 (
    .clk(clk), .nrst(nrst), .extReady(ext_ready), .cpuAddress(cpu_addr),
    .cpuDataOut(cpu_dout), .cpuReadNotWrite(cpu_rnw), .cpuReady(cpu_ready2),
    .cpuDataIn(cpu_din2), .dmaRequest(dma_req), .dmaAddress(dma_addr),
    .dmaWriteData(dma_wdata), .dmaWrite(dma_write), .dmaGrant(dma_grant2),
    .dmaAck(dma_ack2), .dmaReadData(dma_rdata2), .memAddress(mem_addr2),
    .memWriteData(mem_wdata2), .memWriteEnable(mem_we2), .memReadData(mem_rdata2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst      = 1'b0;
    ext_ready = 1'b1;
    cpu_addr  = 16'hFFFC;
    cpu_dout  = 8'h00;
    cpu_rnw   = 1'b1;
    dma_req   = 1'b0;
    dma_addr  = 16'h0000;
    dma_wdata = 8'h00;
    dma_write = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (mem_addr0 !== 16'hFFFC) begin
      n_fail++; $display("FAIL reset_addr: got %h expected FFFC", mem_addr0);
    end
    n_checks++;
    if (cpu_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", cpu_ready0);
    end
    n_checks++;
    if (dma_grant0 !== 1'b0 || dma_ack0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_grant_ack: got %b%b expected 00", dma_grant0, dma_ack0);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    cpu_addr  = 16'hCCDD;
    dma_req   = 1'b1;
    dma_addr  = 16'h0300;
    dma_wdata = 8'h34;
    dma_write = 1'b1;
    #1;
    n_checks++;
    if (mem_addr0 !== 16'hCCDD || cpu_din0 !== 8'h5A) begin
      n_fail++; $display("FAIL pre_grant_bus: got %h/%h expected CCDD/5A", mem_addr0, cpu_din0);
    end
    tick();
    dma_req = 1'b0;
    #1;
    n_checks++;
    if (cpu_ready0 !== 1'b0) begin
      n_fail++; $display("FAIL xfer_ready: got %b expected 0", cpu_ready0);
    end
    n_checks++;
    if (mem_addr0 !== 16'h0300 || mem_wdata0 !== 8'h34) begin
      n_fail++; $display("FAIL xfer_bus: got %h/%h expected 0300/34", mem_addr0, mem_wdata0);
    end
    n_checks++;
    if (mem_we0 !== 1'b1 || dma_ack0 !== 1'b1) begin
      n_fail++; $display("FAIL xfer_we_ack: got %b%b expected 11", mem_we0, dma_ack0);
    end
    tick();
    n_checks++;
    if (mem_addr0 !== 16'hCCDD || cpu_ready0 !== 1'b1 || dma_grant0 !== 1'b0) begin
      n_fail++; $display("FAIL yield: got %h r%b g%b expected CCDD r1 g0",
                         mem_addr0, cpu_ready0, dma_grant0);
    end
  endtask

  task automatic test_cpu_write_defer();
    do_reset();
    cpu_addr = 16'h0100;
    cpu_dout = 8'hFE;
    cpu_rnw  = 1'b0;
    dma_req  = 1'b1;
    dma_addr = 16'h0200;
    #1;
    n_checks++;
    if (mem_wdata0 !== 8'hFE || mem_we0 !== 1'b1 || mem_addr0 !== 16'h0100) begin
      n_fail++; $display("FAIL cpu_write_bus: got %h/%h we%b expected 0100/FE we1",
                         mem_addr0, mem_wdata0, mem_we0);
    end
    tick();
    n_checks++;
    if (dma_grant0 !== 1'b0 || cpu_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL write_no_grant: got g%b r%b expected g0 r1", dma_grant0, cpu_ready0);
    end
    cpu_rnw  = 1'b1;
    cpu_addr = 16'h0101;
    #1;
    n_checks++;
    if (dma_grant0 !== 1'b0 || mem_we0 !== 1'b0) begin
      n_fail++; $display("FAIL read_pre_edge: got g%b we%b expected g0 we0", dma_grant0, mem_we0);
    end
    tick();
    dma_req = 1'b0;
    #1;
    n_checks++;
    if (dma_grant0 !== 1'b1 || mem_addr0 !== 16'h0200 || mem_we0 !== 1'b0) begin
      n_fail++; $display("FAIL read_grant: got g%b %h we%b expected g1 0200 we0",
                         dma_grant0, mem_addr0, mem_we0);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_grant;
    int         acks;
    exp_grant = 7'b1001111;
    acks      = 0;
    do_reset();
    cpu_addr  = 16'h1234;
    dma_req   = 1'b1;
    dma_addr  = 16'h4000;
    dma_write = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (dma_ack0 === 1'b1 && i < 5) acks++;
      n_checks++;
      if (dma_grant0 !== exp_grant[i] || dma_ack0 !== exp_grant[i] ||
          cpu_ready0 !== !exp_grant[i]) begin
        n_fail++; $display("FAIL burst_cycle%0d: got g%b a%b r%b expected g%b a%b r%b", i,
                           dma_grant0, dma_ack0, cpu_ready0, exp_grant[i], exp_grant[i],
                           !exp_grant[i]);
      end
    end
    n_checks++;
    if (acks !== 4) begin
      n_fail++; $display("FAIL burst_ack_count: got %0d expected 4", acks);
    end
    dma_req = 1'b0;
    tick();
    tick();
    tick();
    tick();
  endtask

  task automatic test_wait_states();
    logic [2:0] exp_ack;
    exp_ack = 3'b100;
    do_reset();
    cpu_addr  = 16'h2000;
    dma_req   = 1'b1;
    dma_addr  = 16'hCD31;
    dma_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) dma_req = 1'b0;
      #1;
      n_checks++;
      if (dma_grant2 !== 1'b1 || dma_ack2 !== exp_ack[i] || mem_we2 !== 1'b0) begin
        n_fail++; $display("FAIL wait_cycle%0d: got g%b a%b we%b expected g1 a%b we0", i,
                           dma_grant2, dma_ack2, mem_we2, exp_ack[i]);
      end
    end
    n_checks++;
    if (dma_rdata2 !== 8'hF0) begin
      n_fail++; $display("FAIL wait_rdata: got %h expected F0", dma_rdata2);
    end
    tick();
    n_checks++;
    if (dma_grant2 !== 1'b0 || cpu_ready2 !== 1'b1) begin
      n_fail++; $display("FAIL wait_yield: got g%b r%b expected g0 r1", dma_grant2, cpu_ready2);
    end
  endtask

  task automatic test_ext_ready_and_abort();
    do_reset();
    ext_ready = 1'b0;
    cpu_addr  = 16'h3000;
    #1;
    n_checks++;
    if (cpu_ready0 !== 1'b0 || dma_grant0 !== 1'b0) begin
      n_fail++; $display("FAIL ext_ready_low: got r%b g%b expected r0 g0", cpu_ready0, dma_grant0);
    end
    tick();
    n_checks++;
    if (cpu_ready0 !== 1'b0 || dma_grant0 !== 1'b0) begin
      n_fail++; $display("FAIL ext_ready_hold: got r%b g%b expected r0 g0", cpu_ready0, dma_grant0);
    end
    ext_ready = 1'b1;
    dma_req   = 1'b1;
    dma_addr  = 16'h0500;
    dma_wdata = 8'h77;
    dma_write = 1'b1;
    tick();
    n_checks++;
    if (dma_grant0 !== 1'b1 || mem_we0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_burst_start: got g%b we%b expected g1 we1", dma_grant0, mem_we0);
    end
    tick();
    nrst = 1'b0;
    tick();
    n_checks++;
    if (dma_grant0 !== 1'b0 || dma_ack0 !== 1'b0 || mem_we0 !== 1'b0 || cpu_ready0 !== 1'b1) begin
      n_fail++; $display("FAIL abort_reset: got g%b a%b we%b r%b expected g0 a0 we0 r1",
                         dma_grant0, dma_ack0, mem_we0, cpu_ready0);
    end
    n_checks++;
    if (mem_addr0 !== 16'h3000) begin
      n_fail++; $display("FAIL abort_addr: got %h expected 3000", mem_addr0);
    end
    dma_req = 1'b0;
    nrst    = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_cpu_write_defer();
    test_back_to_back();
    test_wait_states();
    test_ext_ready_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
